// File: rtl/mips_bus_arb_pkg.sv
// Shared types for the CPU bus arbiter: FSM states, per-master request bundle, abort data.
package mips_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } bus_req_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mips_bus_arb_watchdog.sv
// Counts consecutive slave stall cycles of a granted transaction; timeout is combinational from the count.
// Zero latency on timeout once the count reaches WATCHDOG_CYCLES; clear has priority over stall.
module mips_bus_arb_watchdog #(
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic timeout
);

  logic [31:0] count;

  assign timeout = (count >= 32'(WATCHDOG_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (stall) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin two-master arbiter for the shared memory port; grant starts one cycle after the request is seen.
// Losing master is stalled through its waitrequest; a hung slave is aborted by the watchdog with sticky error.
module mips_bus_arbiter
  import mips_bus_arb_pkg::*;
#(
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic        s_waitrequest,
  input  logic [31:0] s_readdata,
  output logic        busy,
  output logic        error
);

  arb_state_t state;
  logic       last;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       req_g;
  logic       done;
  logic       timeout;
  bus_req_t   m0_req, m1_req, s_req;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign gnt0 = (state == GRANT0);
  assign gnt1 = (state == GRANT1);
  assign busy = (state != IDLE);

  assign m0_req = '{m0_address, m0_read, m0_write, m0_writedata, m0_byteenable};
  assign m1_req = '{m1_address, m1_read, m1_write, m1_writedata, m1_byteenable};

  // A dropped request, a slave accept or a watchdog abort all end the grant.
  assign req_g = (gnt0 & req0) | (gnt1 & req1);
  assign done  = busy & (~req_g | ~s_waitrequest | timeout);

  mips_bus_arb_watchdog #(
    .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (~busy | done),
    .stall  (busy & s_waitrequest),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && (!req1 || last)) begin
            state <= GRANT0;
          end else if (req1) begin
            state <= GRANT1;
          end
        end
        GRANT0, GRANT1: begin
          if (done) begin
            state <= IDLE;
            if (req_g) begin
              last <= (state == GRANT1);
            end
            if (timeout) begin
              error <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_req = '0;
    if (gnt0) begin
      s_req = m0_req;
    end else if (gnt1) begin
      s_req = m1_req;
    end
  end

  assign s_address    = s_req.address;
  assign s_read       = s_req.read;
  assign s_write      = s_req.write;
  assign s_writedata  = s_req.writedata;
  assign s_byteenable = s_req.byteenable;

  // An abort releases the granted master even though the slave is still stalling.
  assign m0_waitrequest = gnt0 ? (req0 & s_waitrequest & ~timeout) : req0;
  assign m1_waitrequest = gnt1 ? (req1 & s_waitrequest & ~timeout) : req1;

  assign m0_readdata = (gnt0 && timeout) ? ABORT_DATA : s_readdata;
  assign m1_readdata = (gnt1 && timeout) ? ABORT_DATA : s_readdata;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter: behavioural wait-state RAM, queue scoreboard, completion monitor.
module tb_mips_bus_arbiter;

  localparam int WD = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_read, m0_write, m0_waitrequest;
  logic [3:0]  m0_byteenable;
  logic [31:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_read, m1_write, m1_waitrequest;
  logic [3:0]  m1_byteenable;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic        busy, error;

  always #5 clk = ~clk;

  mips_bus_arbiter #(.WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .busy(busy), .error(error)
  );

  // Slave: 4096-word RAM with a programmable number of wait states per access.
  logic [31:0] mem [0:4095];
  int          wait_states = 0;
  bit          stall_forever = 1'b0;
  int          ws_cnt;

  assign s_waitrequest = stall_forever || ((s_read || s_write) && (ws_cnt < wait_states));
  assign s_readdata    = mem[s_address[13:2]];

  always @(posedge clk or negedge reset) begin
    if (!reset) ws_cnt <= 0;
    else if ((s_read || s_write) && s_waitrequest) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  always @(posedge clk) begin
    if (reset && s_write && !s_waitrequest)
      for (int b = 0; b < 4; b++)
        if (s_byteenable[b]) mem[s_address[13:2]][8*b +: 8] <= s_writedata[8*b +: 8];
  end

  typedef struct {
    int          m;
    bit          chk;
    logic [31:0] data;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int m, input bit chk, input logic [31:0] data);
    exp_t e;
    e.m = m; e.chk = chk; e.data = data;
    expq.push_back(e);
  endtask

  // Monitor: a master completes when it requests and sees waitrequest low.
  always @(negedge clk) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        logic        rq, wr;
        logic [31:0] rd;
        rq = (m == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
        wr = (m == 0) ? m0_waitrequest : m1_waitrequest;
        rd = (m == 0) ? m0_readdata : m1_readdata;
        if (rq && !wr) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_completion: master %0d completed, expected none", m);
          end else begin
            exp_t e;
            e = expq.pop_front();
            check("grant_order", m, e.m);
            if (e.chk) check("readdata", rd, e.data);
          end
        end
      end
    end
  end

  task automatic m_xact(input int m, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
    int n;
    n = 0;
    if (m == 0) begin
      m0_address = addr; m0_read = !wr; m0_write = wr; m0_writedata = wdata; m0_byteenable = be;
    end else begin
      m1_address = addr; m1_read = !wr; m1_write = wr; m1_writedata = wdata; m1_byteenable = be;
    end
    forever begin
      @(negedge clk);
      n++;
      if (!((m == 0) ? m0_waitrequest : m1_waitrequest)) break;
      if (n >= 200) begin
        vectors++;
        miscompares++;
        $display("FAIL xact_timeout: master %0d still waiting after %0d cycles, expected completion", m, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (m == 0) begin
      m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    end else begin
      m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = '0; m1_byteenable = '0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[10]   = 32'hCB4DDA24;   // 0xBFC00028
    mem[128]  = 32'hA5A50001;   // 0x200
    mem[12'h50] = 32'h11223344; // 0x140
    for (int i = 0; i < 4; i++) begin
      mem[32 + i] = 32'hA0000000 + 32'(i);
      mem[40 + i] = 32'hB0000000 + 32'(i);
    end

    // Reset state, and combinational stall while held in reset.
    #1;
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    check("rst_s_read", s_read, 0);
    check("rst_s_write", s_write, 0);
    check("rst_s_address", s_address, 0);
    check("rst_s_byteenable", s_byteenable, 0);
    m0_read = 1'b1;
    #1;
    check("rst_m0_wait_req", m0_waitrequest, 1);
    check("rst_s_read_req", s_read, 0);
    m0_read = 1'b0;
    #1;
    check("rst_m0_wait_idle", m0_waitrequest, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Lone m0 read.
    push(0, 1, 32'hCB4DDA24);
    fork
      m_xact(0, 0, 32'hBFC00028, 32'h0, 4'hF);
      begin
        @(posedge clk);
        @(negedge clk);
        check("t1_busy", busy, 1);
        check("t1_s_read", s_read, 1);
        check("t1_s_address", s_address, 32'hBFC00028);
        check("t1_m1_wait", m1_waitrequest, 0);
      end
    join
    @(negedge clk);
    check("t1_busy_after", busy, 0);
    @(posedge clk);
    #1;

    // Simultaneous m0 write and m1 fetch after reset: m0 first, m1 stalled meanwhile.
    do_reset();
    wait_states = 2;
    push(0, 0, 32'h0);
    push(1, 1, 32'hA5A50001);
    fork
      m_xact(0, 1, 32'h100, 32'h12345678, 4'hF);
      m_xact(1, 0, 32'h200, 32'h0, 4'hF);
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("t2_m0_first", s_write, 1);
          check("t2_m1_stalled", m1_waitrequest, 1);
        end
      end
    join
    wait_states = 0;
    push(1, 1, 32'h12345678);
    m_xact(1, 0, 32'h100, 32'h0, 4'hF);

    // Continuous contention: grants alternate starting with m0.
    for (int i = 0; i < 4; i++) begin
      push(0, 1, 32'hA0000000 + 32'(i));
      push(1, 1, 32'hB0000000 + 32'(i));
    end
    fork
      for (int i = 0; i < 4; i++) m_xact(0, 0, 32'((32 + i) * 4), 32'h0, 4'hF);
      for (int j = 0; j < 4; j++) m_xact(1, 0, 32'((40 + j) * 4), 32'h0, 4'hF);
    join

    // Byte write then readback through the other master.
    push(0, 0, 32'h0);
    fork
      m_xact(0, 1, 32'h140, 32'h0000AB00, 4'b0010);
      begin
        @(posedge clk);
        @(negedge clk);
        check("t4_s_byteenable", s_byteenable, 4'b0010);
        check("t4_s_writedata", s_writedata, 32'h0000AB00);
      end
    join
    push(1, 1, 32'h1122AB44);
    m_xact(1, 0, 32'h140, 32'h0, 4'hF);

    // Hung slave: watchdog aborts after WD stall cycles.
    stall_forever = 1'b1;
    push(1, 1, 32'hDEADBEEF);
    fork
      m_xact(1, 0, 32'h0, 32'h0, 4'hF);
      begin
        int stalls;
        stalls = 0;
        @(posedge clk);
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (busy && m1_waitrequest) stalls++;
          else break;
        end
        check("t5_stall_cycles", stalls, WD);
      end
    join
    @(negedge clk);
    check("t5_error_set", error, 1);
    repeat (5) @(negedge clk);
    check("t5_error_sticky", error, 1);
    check("t5_busy_idle", busy, 0);
    stall_forever = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    check("t5_error_cleared", error, 0);

    // Reset asserted during GRANT1.
    wait_states = 5;
    m1_address = 32'h200;
    m1_read = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_busy_granted", busy, 1);
    check("t6_s_read_granted", s_read, 1);
    #2 reset = 1'b0;
    #1;
    check("t6_s_read_dropped", s_read, 0);
    check("t6_busy_dropped", busy, 0);
    check("t6_m1_wait_in_reset", m1_waitrequest, 1);
    m1_read = 1'b0;
    m1_address = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    wait_states = 0;
    @(posedge clk);
    #1;
    push(0, 1, 32'hCB4DDA24);
    push(1, 1, 32'hA5A50001);
    fork
      m_xact(0, 0, 32'hBFC00028, 32'h0, 4'hF);
      m_xact(1, 0, 32'h200, 32'h0, 4'hF);
    join

    repeat (3) @(posedge clk);
    check("queue_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
